// File: rtl/skew_stream_buf.sv
// skew_stream_buf: per-lane delay lines that skew B-operand rows diagonally into
// the systolic array. Lane i is BASE_DEPTH + i*STEP stages deep. A small FSM
// tracks the tile: after the last row is accepted it self-advances until every
// lane is empty and then pulses done for one cycle.
// Optional build macro SKEW_STREAM_BUF_PERF_EN adds row_cnt and stall_cnt.
//
// state | meaning
// IDLE  | no tile in flight, storage empty or only stale bubbles
// RUN   | rows of a tile being accepted, advances follow en
// DRAIN | last row accepted, self-advancing with bubbles, input blocked
module skew_stream_buf #(
    parameter int BITS_AB    = 8,
    parameter int DIM        = 8,
    parameter int BASE_DEPTH = 8,
    parameter int STEP       = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic signed [DIM-1:0][BITS_AB-1:0] Bin,
    output logic                              in_ready,
    output logic signed [DIM-1:0][BITS_AB-1:0] Bout,
    output logic [DIM-1:0]                    out_valid,
    output logic                              busy,
    output logic                              done
`ifdef SKEW_STREAM_BUF_PERF_EN
    ,
    output logic [15:0]                       row_cnt,
    output logic [15:0]                       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q;
    logic           done_q;
    logic           adv;
    logic           accept;
    logic           empty;
    logic [DIM-1:0] lane_busy;

    assign adv      = en | (state_q == DRAIN);
    assign in_ready = (state_q != DRAIN);
    assign accept   = adv & in_valid & in_ready;
    assign empty    = ~|lane_busy;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam int D = BASE_DEPTH + i * STEP;

        logic [D-1:0]              vld_q;
        logic [D-1:0][BITS_AB-1:0] dat_q;

        // Lane delay line: shift on every advance, writing the row or a zero bubble.
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                vld_q <= '0;
                dat_q <= '0;
            end else if (adv) begin
                for (int s = D - 1; s > 0; s--) begin
                    vld_q[s] <= vld_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
                vld_q[0] <= accept;
                dat_q[0] <= accept ? Bin[i] : '0;
            end
        end

        assign Bout[i]      = dat_q[D-1];
        assign out_valid[i] = vld_q[D-1];
        assign lane_busy[i] = |vld_q;
    end

    // Tile sequencing and the registered drain-complete pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= in_last ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (accept && in_last) begin
                        state_q <= DRAIN;
                    end else if (empty && !accept) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SKEW_STREAM_BUF_PERF_EN
    logic [15:0] row_cnt_q;
    logic [15:0] stall_cnt_q;

    // Accepted-row and blocked-input counters; both wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            row_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                row_cnt_q <= row_cnt_q + 16'd1;
            end
            if (in_valid && !in_ready) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign row_cnt   = row_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skew_stream_buf.sv
// Directed bench for skew_stream_buf with DIM=4, BASE_DEPTH=4, STEP=1 (depths 4..7).
// A per-advance history of written rows predicts every lane output.
module tb_skew_stream_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic        in_last;
    logic [31:0] bin;
    logic        in_ready;
    logic [31:0] bout;
    logic [3:0]  out_valid;
    logic        busy;
    logic        done;
`ifdef SKEW_STREAM_BUF_PERF_EN
    logic [15:0] row_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n      = 0;
    bit          hist_v [0:63];
    logic [31:0] hist_d [0:63];

    always #5 clk = ~clk;

    skew_stream_buf #(
        .BITS_AB   (8),
        .DIM       (4),
        .BASE_DEPTH(4),
        .STEP      (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .in_last  (in_last),
        .Bin      (bin),
        .in_ready (in_ready),
        .Bout     (bout),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
`ifdef SKEW_STREAM_BUF_PERF_EN
        ,
        .row_cnt  (row_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        n = 0;
        for (int k = 0; k < 64; k++) begin
            hist_v[k] = 1'b0;
            hist_d[k] = 32'h0;
        end
    endtask

    // One clock; if do_adv, record what stage 0 should have captured, then check all lanes.
    task automatic cyc(input string tag, input bit do_adv, input bit acc);
        logic [3:0]  ev;
        logic [31:0] ed;
        int          m;
        step();
        if (do_adv) begin
            n++;
            hist_v[n] = acc;
            hist_d[n] = acc ? bin : 32'h0;
        end
        ev = '0;
        ed = '0;
        for (int i = 0; i < 4; i++) begin
            m = n - (4 + i) + 1;
            if (m >= 1) begin
                ev[i]        = hist_v[m];
                ed[i*8 +: 8] = hist_d[m][i*8 +: 8];
            end
        end
        chk($sformatf("%s_out_valid_n%0d", tag, n), {28'h0, out_valid}, {28'h0, ev});
        chk($sformatf("%s_bout_n%0d", tag, n), bout, ed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with active inputs
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        bin = 32'h0403_0201;
        repeat (3) step();
        chk("rst_bout", bout, 32'h0);
        chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;
        step();

        // in_last without in_valid does nothing
        en = 1'b1; in_last = 1'b1;
        step();
        chk("last_novalid_busy", {31'h0, busy}, 32'h0);
        en = 1'b0; in_last = 1'b0;
        step();

        // Single last row, then drain with en=0 while 99 is offered
        clear_hist();
        bin = 32'h0403_0201; in_valid = 1'b1; in_last = 1'b1; en = 1'b1;
        cyc("single", 1'b1, 1'b1);
        chk("single_busy_k", {31'h0, busy}, 32'h1);
        chk("single_in_ready_k", {31'h0, in_ready}, 32'h0);
        bin = 32'h6363_6363; in_valid = 1'b1; in_last = 1'b0; en = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            cyc("single", (j <= 8), 1'b0);
            chk($sformatf("single_done_j%0d", j), {31'h0, done}, {31'h0, (j == 8)});
            chk($sformatf("single_busy_j%0d", j), {31'h0, busy}, {31'h0, (j < 8)});
            chk($sformatf("single_in_ready_j%0d", j), {31'h0, in_ready}, {31'h0, (j >= 8)});
        end
        in_valid = 1'b0;
        step();

        // Bubble insertion: 5,0,5,0 then bubbles until RUN falls back to IDLE
        clear_hist();
        bin = 32'h0505_0505; en = 1'b1; in_last = 1'b0;
        for (int j = 0; j < 12; j++) begin
            in_valid = (j < 4) ? ((j % 2) == 0) : 1'b0;
            cyc("bubble", 1'b1, in_valid);
            chk($sformatf("bubble_done_j%0d", j), {31'h0, done}, 32'h0);
        end
        chk("bubble_busy_end", {31'h0, busy}, 32'h0);

        // Stall: rows 10, 20, two bubbles, 5 frozen cycles, last row 30, drain
        clear_hist();
        en = 1'b1; in_valid = 1'b1; in_last = 1'b0;
        bin = 32'h0a0a_0a0a;
        cyc("stall", 1'b1, 1'b1);
        bin = 32'h1414_1414;
        cyc("stall", 1'b1, 1'b1);
        in_valid = 1'b0;
        cyc("stall", 1'b1, 1'b0);
        cyc("stall", 1'b1, 1'b0);
        en = 1'b0; in_valid = 1'b1; bin = 32'h4d4d_4d4d;
        for (int j = 0; j < 5; j++) begin
            cyc("stall_hold", 1'b0, 1'b0);
        end
        chk("stall_busy", {31'h0, busy}, 32'h1);
        en = 1'b1; in_valid = 1'b1; in_last = 1'b1; bin = 32'h1e1e_1e1e;
        cyc("stall", 1'b1, 1'b1);
        en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc("stall_drain", 1'b1, 1'b0);
            chk($sformatf("stall_done_j%0d", j), {31'h0, done}, {31'h0, (j == 8)});
        end
        cyc("stall_after", 1'b0, 1'b0);
        chk("stall_done_after", {31'h0, done}, 32'h0);

        // Flush two cycles after the last accepted row
        clear_hist();
        en = 1'b1; in_valid = 1'b1; in_last = 1'b1; bin = 32'h0707_0707;
        cyc("flushd", 1'b1, 1'b1);
        en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        cyc("flushd", 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", {28'h0, out_valid}, 32'h0);
        chk("flush_bout", bout, 32'h0);
        chk("flush_busy", {31'h0, busy}, 32'h0);
`ifdef SKEW_STREAM_BUF_PERF_EN
        chk("flush_row_cnt", {16'h0, row_cnt}, 32'h0);
`endif
        for (int j = 0; j < 20; j++) begin
            step();
            chk($sformatf("flush_done_j%0d", j), {31'h0, done}, 32'h0);
            chk($sformatf("flush_ov_j%0d", j), {28'h0, out_valid}, 32'h0);
        end

        // Row presented during a flush cycle from IDLE is dropped
        en = 1'b1; in_valid = 1'b1; bin = 32'h1111_1111; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("flush_drop_ov_j%0d", j), {28'h0, out_valid}, 32'h0);
            chk($sformatf("flush_drop_busy_j%0d", j), {31'h0, busy}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
